load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-side initiator for the unified instruction/data memory: accepts load/store requests from the CPU pipeline over a valid/ready handshake and drives that memory's combinational data port (`mem_addr`, `mem_wdata`, `mem_read`, `mem_write`, `mem_rdata`). It supports byte, halfword and word accesses, detects errors, and performs read-modify-write for sub-word stores. It produces `mem_write` as a clean single-cycle pulse with address and data stable around it, because the memory writes on the level and edges of that signal.

## Interface
- `DATA_LIMIT`, default 32'h0000_3000: first byte address outside the data region; accesses at or above it are rejected.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed`  in  1  sign-extend sub-word loads (ignored for stores and words).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  response present; held until taken.
- `resp_ready`  in  1  pipeline takes response.
- `resp_rdata`  out  32  load result, extended to 32 bits; 0 for stores and errors.
- `resp_err`  out  1  request was rejected; no memory access occurred.
- `mem_addr`  out  32  word-aligned data address (`req_addr & ~3`).
- `mem_wdata`  out  32  full word to write.
- `mem_read`  out  1  read enable to memory.
- `mem_write`  out  1  write strobe to memory.
- `mem_rdata`  in  32  little-endian word from memory, valid in the same cycle as `mem_read`.

## Operation
- Accept: `req_valid && req_ready` at a rising edge. All request fields are captured into registers, and nothing reads the request inputs afterwards.
- Error check at accept:
  - `req_size`=11 is an error.
  - Halfword with `addr[0]`=1 is an error.
  - Word with `addr[1:0]`≠0 is an error.
  - Any access with `req_addr >= DATA_LIMIT` is an error.
  - On error, go to RESP with `resp_err`=1, `resp_rdata`=0, and no `mem_read`/`mem_write` activity.
- States and transitions:
  - IDLE: on accept, go to RESP if error; go to WR_SETUP if word store; otherwise go to RD.
  - RD: `mem_read`=1. `mem_rdata` is captured at the end of the cycle. A load goes to RESP; a sub-word store goes to WR_SETUP.
  - WR_SETUP: `mem_addr`/`mem_wdata` are driven and `mem_write`=0.
  - WR_PULSE: `mem_write`=1 for exactly one cycle. `mem_addr`/`mem_wdata` are unchanged. Go to RESP.
  - RESP: `resp_valid`=1. On `resp_ready`, go to IDLE.
- Lane rules, where `addr[1:0]` selects the lane within a little-endian word:
  - Byte load: `rdata[8*k+7:8*k]`, with k = `addr[1:0]`.
  - Halfword load: `rdata[16*h+15:16*h]`, with h = `addr[1]`.
  - Sub-word loads are zero- or sign-extended per `req_signed`.
- Sub-word store merge: `mem_wdata` = the read word with only the addressed lane(s) replaced by `req_wdata[7:0]` or `req_wdata[15:0]`. A word store writes `req_wdata` directly.
- `mem_addr` and `mem_wdata` are registered and held from WR_SETUP until the next accepted request. They never change while `mem_write`=1 or in the cycle after it falls.
- `mem_read` and `mem_write` are never high together.

## Timing
- Accept edge = cycle 0. `resp_valid` rises after:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 3 cycles
  - sub-word store: 4 cycles
- Back-to-back throughput: one request per (latency + 1) cycles when `resp_ready` is tied high. `req_ready` reasserts in the cycle after the response is taken.
- Reset values of outputs: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_addr`=0, `mem_wdata`=0, `mem_read`=0, `mem_write`=0. State resets to IDLE.
- Reset mid-operation: all outputs drop asynchronously to their reset values and any pending response is discarded.
  - Reset in RD or WR_SETUP: memory is not modified.
  - Reset in WR_PULSE: the write has already landed on the strobe's rising edge and is not undone.
- `resp_valid` high with `resp_ready` low: the unit stalls in RESP with `resp_rdata`/`resp_err` stable, and `req_ready` stays 0.

## Structure
- The `lsu_pkg` package holds:
  - the state enum (IDLE, RD, WR_SETUP, WR_PULSE, RESP)
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the default `DATA_LIMIT` constant
- Sub-module `lsu_lane_align` is combinational. It performs load extraction/extension and store merge from (`addr[1:0]`, size, signed, word, wdata). The top level holds the FSM and registers.

## Test plan
- Word load at 0x0010, memory word 0xDEADBEEF → `mem_read` high one cycle, `mem_addr`=0x0010, `resp_rdata`=0xDEADBEEF 2 cycles after accept, `resp_err`=0.
- Signed byte load at 0x0013 over word 0x80FF_0102 → `resp_rdata`=0xFFFF_FF80; the unsigned load gives 0x0000_0080.
- Byte store 0xAB at 0x0021 over word 0x1122_3344:
  - RD, then `mem_wdata`=0x1122_AB44 with a single-cycle `mem_write`
  - `mem_addr`=0x0020 stable from WR_SETUP through the cycle after the pulse
  - response after 4 cycles
- Errors each give `resp_err`=1 after 1 cycle, with no `mem_read` or `mem_write` toggling:
  - halfword at 0x0005
  - word at 0x0002
  - size 11
  - word at 0x3000
- Hold `resp_ready`=0 for 5 cycles on a load → `resp_valid` and `resp_rdata` stable and `req_ready`=0. Then assert `rst_n`=0 during WR_PULSE of a following store → `mem_write` falls immediately, all outputs take reset values, and `req_ready`=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access
// size encodings, default data-region limit and the request error check.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SETUP,
      WR_PULSE,
      RESP
   } lsu_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam logic [31:0] DATA_LIMIT_DEFAULT = 32'h0000_3000;

   // Rejects illegal size, misalignment and anything outside the data region.
   function automatic logic access_error(input logic [1:0]  size,
                                         input logic [31:0] addr,
                                         input logic [31:0] limit);
      logic err;
      err = (addr >= limit);
      case (size)
         SZ_HALF: err = err | addr[0];
         SZ_WORD: err = err | (|addr[1:0]);
         SZ_ILL:  err = 1'b1;
         default: err = err;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends sub-word loads from a memory word
// and merges sub-word store data into it.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   logic [31:0] shifted;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;
   logic [4:0]  shamt;

   always_comb begin
      load_data  = '0;
      store_data = word;
      shifted    = '0;
      lane_mask  = '0;
      lane_data  = '0;
      shamt      = '0;
      case (size)
         SZ_BYTE: begin
            shamt      = {addr_lo, 3'b000};
            shifted    = word >> shamt;
            load_data  = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            lane_mask  = 32'h0000_00FF << shamt;
            lane_data  = {24'h0, wdata[7:0]} << shamt;
            store_data = (word & ~lane_mask) | lane_data;
         end
         SZ_HALF: begin
            shamt      = {addr_lo[1], 4'b0000};
            shifted    = word >> shamt;
            load_data  = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            lane_mask  = 32'h0000_FFFF << shamt;
            lane_data  = {16'h0, wdata[15:0]} << shamt;
            store_data = (word & ~lane_mask) | lane_data;
         end
         default: begin
            load_data  = word;
            store_data = wdata;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit: valid/ready request/response front end driving a
// combinational memory port, with read-modify-write for sub-word stores.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter logic [31:0] DATA_LIMIT = DATA_LIMIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic        req_err;
   logic [31:0] load_data;
   logic [31:0] store_data;

   lsu_lane_align u_lane_align (
      .addr_lo    (addr_lo_q),
      .size       (size_q),
      .is_signed  (signed_q),
      .word       (mem_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   assign req_err = access_error(req_size, req_addr, DATA_LIMIT);

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      signed_d     = signed_q;
      addr_lo_d    = addr_lo_q;
      wdata_d      = wdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d      = req_write;
               size_d       = req_size;
               signed_d     = req_signed;
               addr_lo_d    = req_addr[1:0];
               wdata_d      = req_wdata;
               resp_rdata_d = '0;
               resp_err_d   = req_err;
               // Rejected requests leave the memory port registers untouched.
               if (req_err) begin
                  state_d = RESP;
               end else begin
                  mem_addr_d = {req_addr[31:2], 2'b00};
                  if (req_write && (req_size == SZ_WORD)) begin
                     mem_wdata_d = req_wdata;
                     state_d     = WR_SETUP;
                  end else begin
                     state_d = RD;
                  end
               end
            end
         end
         RD: begin
            if (write_q) begin
               mem_wdata_d = store_data;
               state_d     = WR_SETUP;
            end else begin
               resp_rdata_d = load_data;
               state_d      = RESP;
            end
         end
         WR_SETUP: state_d = WR_PULSE;
         WR_PULSE: state_d = RESP;
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Strobes come straight from flops so mem_write is glitch-free.
      mem_read_d  = (state_d == RD);
      mem_write_d = (state_d == WR_PULSE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         size_q       <= SZ_BYTE;
         signed_q     <= 1'b0;
         addr_lo_q    <= '0;
         wdata_q      <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         addr_lo_q    <= addr_lo_d;
         wdata_q      <= wdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single requests plus
// hand-written sequences for strobe timing, response stall and mid-op reset.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;

   load_store_unit #(.DATA_LIMIT(32'h0000_3000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the rising edge of the strobe.
   logic [31:0] mem [0:4095];
   assign mem_rdata = mem[mem_addr[13:2]];
   always @(posedge mem_write) mem[mem_addr[13:2]] = mem_wdata;

   int          rd_cnt = 0, wr_cnt = 0, overlap = 0, stab_bad = 0;
   logic        wr_prev = 1'b0;
   logic [31:0] pulse_addr = '0, pulse_wdata = '0;

   always @(posedge mem_write) begin
      pulse_addr  = mem_addr;
      pulse_wdata = mem_wdata;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         wr_prev = 1'b0;
      end else begin
         if (mem_read) rd_cnt++;
         if (mem_write) wr_cnt++;
         if (mem_read && mem_write) overlap++;
         if ((mem_write || wr_prev) && (mem_addr !== pulse_addr || mem_wdata !== pulse_wdata))
            stab_bad++;
         wr_prev = mem_write;
      end
   end

   int total = 0;
   int bad = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_write  = ~wr;
      req_size   = 2'b11;
      req_signed = ~sgn;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h5555_5555;
      @(negedge clk);
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic        chk_mem;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      logic [31:0] mem_after;
      int          rds;
      int          wrs;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, r0, w0;
      logic exp_rd [4];
      logic exp_wr [4];
      logic exp_rv [4];

      for (int i = 0; i < 4096; i++) mem[i] = '0;
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

      //        wr    sz       sgn   addr          wdata         init          chk   err   rdata         lat mem_after     rd wr
      vecs[0]  = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1, 0};
      vecs[1]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_0013, 32'h0,        32'h80FF_0102, 1'b1, 1'b0, 32'hFFFF_FF80, 2, 32'h80FF_0102, 1, 0};
      vecs[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_0013, 32'h0,        32'h80FF_0102, 1'b1, 1'b0, 32'h0000_0080, 2, 32'h80FF_0102, 1, 0};
      vecs[3]  = '{1'b0, SZ_HALF, 1'b1, 32'h0000_0016, 32'h0,        32'h8001_7FFF, 1'b1, 1'b0, 32'hFFFF_8001, 2, 32'h8001_7FFF, 1, 0};
      vecs[4]  = '{1'b0, SZ_HALF, 1'b0, 32'h0000_0014, 32'h0,        32'h8001_7FFF, 1'b1, 1'b0, 32'h0000_7FFF, 2, 32'h8001_7FFF, 1, 0};
      vecs[5]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_0018, 32'h0,        32'hFFFF_807F, 1'b1, 1'b0, 32'h0000_007F, 2, 32'hFFFF_807F, 1, 0};
      vecs[6]  = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_0021, 32'h0000_00AB, 32'h1122_3344, 1'b1, 1'b0, 32'h0,        4, 32'h1122_AB44, 1, 1};
      vecs[7]  = '{1'b1, SZ_HALF, 1'b0, 32'h0000_0026, 32'h1234_BEEF, 32'hAAAA_AAAA, 1'b1, 1'b0, 32'h0,        4, 32'hBEEF_AAAA, 1, 1};
      vecs[8]  = '{1'b1, SZ_WORD, 1'b0, 32'h0000_0028, 32'hCAFE_F00D, 32'h0,        1'b1, 1'b0, 32'h0,        3, 32'hCAFE_F00D, 0, 1};
      vecs[9]  = '{1'b1, SZ_BYTE, 1'b1, 32'h0000_002F, 32'hFFFF_FF5A, 32'h0102_0304, 1'b1, 1'b0, 32'h0,        4, 32'h5A02_0304, 1, 1};
      vecs[10] = '{1'b1, SZ_HALF, 1'b0, 32'h0000_0005, 32'h0000_1234, 32'h5555_5555, 1'b1, 1'b1, 32'h0,        1, 32'h5555_5555, 0, 0};
      vecs[11] = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0002, 32'h0,        32'h6666_6666, 1'b1, 1'b1, 32'h0,        1, 32'h6666_6666, 0, 0};
      vecs[12] = '{1'b0, SZ_ILL,  1'b0, 32'h0000_0030, 32'h0,        32'h7777_7777, 1'b1, 1'b1, 32'h0,        1, 32'h7777_7777, 0, 0};
      vecs[13] = '{1'b0, SZ_WORD, 1'b0, 32'h0000_3000, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        1, 32'h0,        0, 0};
      vecs[14] = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_3001, 32'h0000_00EE, 32'h0,        1'b0, 1'b1, 32'h0,        1, 32'h0,        0, 0};
      vecs[15] = '{1'b0, SZ_HALF, 1'b1, 32'h0000_2FFE, 32'h0,        32'hABCD_0000, 1'b1, 1'b0, 32'hFFFF_ABCD, 2, 32'hABCD_0000, 1, 0};

      // Reset values
      #12;
      check32("rst_req_ready",  {31'b0, req_ready},  32'd1);
      check32("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check32("rst_resp_rdata", resp_rdata,          32'd0);
      check32("rst_resp_err",   {31'b0, resp_err},   32'd0);
      check32("rst_mem_addr",   mem_addr,            32'd0);
      check32("rst_mem_wdata",  mem_wdata,           32'd0);
      check32("rst_mem_read",   {31'b0, mem_read},   32'd0);
      check32("rst_mem_write",  {31'b0, mem_write},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Vector table, resp_ready tied high
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].chk_mem) mem[vecs[i].addr[13:2]] = vecs[i].init;
         r0 = rd_cnt;
         w0 = wr_cnt;
         do_req(vecs[i].wr, vecs[i].sz, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, lat);
         check32($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check32($sformatf("v%0d_err", i), {31'b0, resp_err}, {31'b0, vecs[i].err});
         check32($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].rdata);
         @(negedge clk);
         check32($sformatf("v%0d_ready_after", i), {31'b0, req_ready}, 32'd1);
         #1;
         check32($sformatf("v%0d_reads", i), 32'(rd_cnt - r0), 32'(vecs[i].rds));
         check32($sformatf("v%0d_writes", i), 32'(wr_cnt - w0), 32'(vecs[i].wrs));
         if (vecs[i].chk_mem)
            check32($sformatf("v%0d_mem", i), mem[vecs[i].addr[13:2]], vecs[i].mem_after);
      end

      // Byte store cycle by cycle: RD, WR_SETUP, WR_PULSE, RESP
      exp_rd = '{1'b1, 1'b0, 1'b0, 1'b0};
      exp_wr = '{1'b0, 1'b0, 1'b1, 1'b0};
      exp_rv = '{1'b0, 1'b0, 1'b0, 1'b1};
      mem[32'h21 >> 2] = 32'h1122_3344;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
      req_addr = 32'h0000_0021; req_wdata = 32'h0000_00AB;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check32($sformatf("bs_c%0d_read", c + 1),  {31'b0, mem_read},   {31'b0, exp_rd[c]});
         check32($sformatf("bs_c%0d_write", c + 1), {31'b0, mem_write},  {31'b0, exp_wr[c]});
         check32($sformatf("bs_c%0d_valid", c + 1), {31'b0, resp_valid}, {31'b0, exp_rv[c]});
         check32($sformatf("bs_c%0d_addr", c + 1),  mem_addr, 32'h0000_0020);
         if (c > 0) check32($sformatf("bs_c%0d_wdata", c + 1), mem_wdata, 32'h1122_AB44);
      end
      @(negedge clk);

      // Response stall
      resp_ready = 1'b0;
      mem[32'h10 >> 2] = 32'hDEAD_BEEF;
      do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0, lat);
      check32("stall_latency", 32'(lat), 32'd2);
      for (int k = 0; k < 5; k++) begin
         check32($sformatf("stall%0d_valid", k), {31'b0, resp_valid}, 32'd1);
         check32($sformatf("stall%0d_rdata", k), resp_rdata, 32'hDEAD_BEEF);
         check32($sformatf("stall%0d_req_ready", k), {31'b0, req_ready}, 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      check32("stall_release_ready", {31'b0, req_ready}, 32'd1);

      // Reset during RD of a sub-word store: memory untouched
      mem[32'h40 >> 2] = 32'hA5A5_A5A5;
      w0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = SZ_BYTE;
      req_addr = 32'h0000_0041; req_wdata = 32'h0000_0000;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check32("rdrst_in_rd", {31'b0, mem_read}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check32("rdrst_read_low", {31'b0, mem_read}, 32'd0);
      check32("rdrst_req_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check32("rdrst_mem", mem[32'h40 >> 2], 32'hA5A5_A5A5);
      check32("rdrst_writes", 32'(wr_cnt - w0), 32'd0);

      // Reset during WR_PULSE of a word store: write lands, outputs reset
      mem[32'h44 >> 2] = 32'h0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD;
      req_addr = 32'h0000_0044; req_wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!mem_write && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check32("wprst_pulse_seen", {31'b0, mem_write}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check32("wprst_mem_write",  {31'b0, mem_write},  32'd0);
      check32("wprst_mem_read",   {31'b0, mem_read},   32'd0);
      check32("wprst_mem_addr",   mem_addr,            32'd0);
      check32("wprst_mem_wdata",  mem_wdata,           32'd0);
      check32("wprst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check32("wprst_resp_rdata", resp_rdata,          32'd0);
      check32("wprst_resp_err",   {31'b0, resp_err},   32'd0);
      check32("wprst_mem_landed", mem[32'h44 >> 2],    32'h1234_5678);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check32("wprst_req_ready", {31'b0, req_ready}, 32'd1);
      check32("wprst_no_resp",   {31'b0, resp_valid}, 32'd0);

      do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0044, 32'h0, lat);
      check32("post_rst_latency", 32'(lat), 32'd2);
      check32("post_rst_rdata", resp_rdata, 32'h1234_5678);
      @(negedge clk);

      check32("strobe_overlap", 32'(overlap), 32'd0);
      check32("write_addr_data_stability", 32'(stab_bad), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
